// File: rtl/rx_uart_param.sv
// Parametrised UART receiver with majority-vote sampling,
// optional parity, 1/2 stop bits, receive FIFO and sticky errors.
module rx_uart_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          brg_en,
    input  logic                          rxd,
    input  logic                          rd_en,
    input  logic                          clear_err,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rda,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        r_ones;
    logic [BW-1:0]        r_bitn;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_bad_frame;
    logic                 r_bad_par;
    logic                 r_commit;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_count;

    logic [CW-1:0]        w_cnt_nxt;
    logic [CW-1:0]        w_ones_nxt;
    logic                 w_bit_done;
    logic                 w_bit;
    logic                 w_commit_ok;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_ovr;

    assign w_cnt_nxt   = r_cnt + 1'b1;
    assign w_ones_nxt  = r_ones + {{(CW-1){1'b0}}, r_sync2};
    assign w_bit_done  = (w_cnt_nxt == CW'(OVERSAMPLE));
    assign w_bit       = (w_ones_nxt > CW'(OVERSAMPLE / 2));

    assign w_commit_ok = r_commit && !r_bad_frame && !r_bad_par;
    assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop       = rd_en && (r_count != '0);
    assign w_push      = w_commit_ok && (!w_full || w_pop);
    assign w_ovr       = w_commit_ok && w_full && !w_pop;

    assign rda         = (r_count != '0);
    assign fifo_count  = r_count;
    assign rx_data     = rda ? r_mem[r_rptr] : '0;

    // Two-flop synchroniser for the asynchronous line (idle high)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM: majority-vote each bit, then commit one clock after the last stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ones      <= '0;
            r_bitn      <= '0;
            r_shift     <= '0;
            r_bad_frame <= 1'b0;
            r_bad_par   <= 1'b0;
            r_commit    <= 1'b0;
        end else if (r_commit) begin
            r_commit <= 1'b0;
            r_state  <= S_IDLE;
        end else if (brg_en) begin
            if (r_state == S_IDLE) begin
                if (!r_sync2) begin
                    r_state <= S_START;
                    r_cnt   <= CW'(1);
                    r_ones  <= '0;
                end
            end else if (!w_bit_done) begin
                r_cnt  <= w_cnt_nxt;
                r_ones <= w_ones_nxt;
            end else begin
                r_cnt  <= '0;
                r_ones <= '0;
                case (r_state)
                    S_START: begin
                        if (w_bit) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state     <= S_DATA;
                            r_bitn      <= '0;
                            r_bad_frame <= 1'b0;
                            r_bad_par   <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        if (r_bitn == BW'(DATA_BITS - 1)) begin
                            r_bitn  <= '0;
                            r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bitn <= r_bitn + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if ((w_bit ^ (^r_shift)) != 1'(PARITY_ODD))
                            r_bad_par <= 1'b1;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        if (!w_bit)
                            r_bad_frame <= 1'b1;
                        if (r_bitn == BW'(STOP_BITS - 1)) begin
                            r_bitn   <= '0;
                            r_commit <= 1'b1;
                        end else begin
                            r_bitn <= r_bitn + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Receive FIFO storage; no reset needed, contents gated by count
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= r_shift;
    end

    // FIFO pointers and occupancy; simultaneous push and pop keeps count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error wins over clear_err
    always_ff @(posedge clk) begin
        if (rst) begin
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= (r_commit && r_bad_frame)
                        || (framing_err && !clear_err);
            parity_err  <= (r_commit && !r_bad_frame && r_bad_par)
                        || (parity_err && !clear_err);
            overrun     <= w_ovr || (overrun && !clear_err);
        end
    end

endmodule
